// File: rtl/karaoke_audio_pkg.sv
// Shared types, widths and the 16-bit saturation helper for the audio playback path.
package karaoke_audio_pkg;

  localparam int unsigned DEF_SAMPLE_W = 16;
  localparam int unsigned DEF_VOL_W    = 7;
  // signed sample times zero-extended volume code
  localparam int unsigned PROD_W       = DEF_SAMPLE_W + DEF_VOL_W + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} play_state_t;
  typedef enum logic [1:0] {V_IDLE, V_PEND, V_ACK} vol_state_t;

  // Clamp a scaled product into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [PROD_W-1:0] r);
    logic [15:0] res;
    if (r > 24'sd32767) begin
      res = 16'h7FFF;
    end else if (r < -24'sd32768) begin
      res = 16'h8000;
    end else begin
      res = r[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_play_ctrl_if.sv
// FIFO stream, volume handshake and DAC output bundle of the playback controller.
interface audio_play_ctrl_if;
  import karaoke_audio_pkg::*;

  logic                    fifo_valid;
  logic [31:0]             fifo_data;
  logic                    fifo_ready;
  logic                    vol_req;
  logic [DEF_VOL_W-1:0]    vol_level;
  logic                    vol_set;
  logic                    vol_ready;
  logic [DEF_SAMPLE_W-1:0] dac_left;
  logic [DEF_SAMPLE_W-1:0] dac_right;
  logic                    dac_valid;

  // Playback controller side.
  modport slave (
    input  fifo_valid, fifo_data, vol_req, vol_level,
    output fifo_ready, vol_set, vol_ready, dac_left, dac_right, dac_valid
  );

  // SoC / FIFO / HPS side.
  modport master (
    output fifo_valid, fifo_data, vol_req, vol_level,
    input  fifo_ready, vol_set, vol_ready, dac_left, dac_right, dac_valid
  );
endinterface

// File: rtl/vol_scale_sat.sv
// One audio channel: registered volume multiply with arithmetic shift and saturation.
module vol_scale_sat
  import karaoke_audio_pkg::*;
#(
  parameter int unsigned VOL_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DEF_SAMPLE_W-1:0] sample,
  input  logic [DEF_VOL_W-1:0]    vol,
  output logic [DEF_SAMPLE_W-1:0] dout
);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Volume is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    prod    = $signed(sample) * $signed({1'b0, vol});
    shifted = prod >>> VOL_SHIFT;
  end

  // Output register; holds its value between sample strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (en) begin
      dout <= sat16(shifted);
    end
  end

endmodule

// File: rtl/audio_play_ctrl.sv
// Audio playback controller: drains the stereo FIFO at fs, gates on play_en, applies
// saturating volume and runs the HPS volume-update handshake.
module audio_play_ctrl
  import karaoke_audio_pkg::*;
#(
  parameter int unsigned VOL_SHIFT     = 6,
  parameter int unsigned VOL_DEFAULT   = 64,
  parameter int unsigned UCNT_W        = 16,
  parameter bit          FLUSH_ON_STOP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play_en,
  audio_play_ctrl_if.slave  bus,
  output logic              playing,
  output logic [UCNT_W-1:0] underrun_cnt
);

  play_state_t state_q, state_d;
  vol_state_t  vstate_q, vstate_d;

  logic [DEF_VOL_W-1:0]    vol_q, vol_d;
  logic [DEF_VOL_W-1:0]    pend_q, pend_d;
  logic [UCNT_W-1:0]       ucnt_q;
  logic [DEF_SAMPLE_W-1:0] s0_left_q, s0_right_q;
  logic [DEF_SAMPLE_W-1:0] sel_left, sel_right;
  logic                    s0_valid_q;
  logic                    dac_valid_q;
  logic                    xfer;
  logic                    underrun;

  // FIFO handshake, underrun detect and stage-0 sample select.
  always_comb begin
    bus.fifo_ready = sample_tick & ((state_q != IDLE) | FLUSH_ON_STOP);
    xfer           = bus.fifo_ready & bus.fifo_valid;
    underrun       = sample_tick & (state_q == RUN) & ~bus.fifo_valid;
    sel_left       = '0;
    sel_right      = '0;
    // Words flushed while idle are consumed but replaced by silence.
    if (xfer && (state_q != IDLE)) begin
      sel_left  = bus.fifo_data[31:16];
      sel_right = bus.fifo_data[15:0];
    end
  end

  // Main play FSM next state.
  always_comb begin
    state_d = state_q;
    if (!play_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (sample_tick && bus.fifo_valid) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Volume handshake FSM next state and commit of the pending volume.
  always_comb begin
    vstate_d = vstate_q;
    pend_d   = pend_q;
    vol_d    = vol_q;
    unique case (vstate_q)
      V_IDLE: begin
        if (bus.vol_req) begin
          pend_d   = bus.vol_level;
          vstate_d = V_PEND;
        end
      end
      V_PEND: begin
        // While running, commit only on a tick so a gain change lines up with a sample.
        if ((state_q != RUN) || sample_tick || !play_en) begin
          vol_d    = pend_q;
          vstate_d = V_ACK;
        end
      end
      V_ACK: begin
        if (!bus.vol_req) vstate_d = V_IDLE;
      end
      default: vstate_d = V_IDLE;
    endcase
  end

  // State, volume and underrun counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vstate_q <= V_IDLE;
      vol_q    <= DEF_VOL_W'(VOL_DEFAULT);
      pend_q   <= DEF_VOL_W'(VOL_DEFAULT);
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      vstate_q <= vstate_d;
      vol_q    <= vol_d;
      pend_q   <= pend_d;
      if (underrun && (ucnt_q != '1)) ucnt_q <= ucnt_q + 1'b1;
    end
  end

  // Stage-0 sample register and valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      s0_left_q   <= '0;
      s0_right_q  <= '0;
      dac_valid_q <= 1'b0;
    end else begin
      s0_valid_q  <= sample_tick;
      dac_valid_q <= s0_valid_q;
      if (sample_tick) begin
        s0_left_q  <= sel_left;
        s0_right_q <= sel_right;
      end
    end
  end

  vol_scale_sat #(
    .VOL_SHIFT (VOL_SHIFT)
  ) u_scale_left (
    .clk    (clk),
    .reset  (reset),
    .en     (s0_valid_q),
    .sample (s0_left_q),
    .vol    (vol_q),
    .dout   (bus.dac_left)
  );

  vol_scale_sat #(
    .VOL_SHIFT (VOL_SHIFT)
  ) u_scale_right (
    .clk    (clk),
    .reset  (reset),
    .en     (s0_valid_q),
    .sample (s0_right_q),
    .vol    (vol_q),
    .dout   (bus.dac_right)
  );

  // Registered-state decodes driven out.
  always_comb begin
    bus.dac_valid = dac_valid_q;
    bus.vol_ready = (vstate_q == V_IDLE);
    bus.vol_set   = (vstate_q == V_ACK);
    playing       = (state_q == RUN);
    underrun_cnt  = ucnt_q;
  end

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Self-checking bench for audio_play_ctrl: scoreboard of expected DAC pairs plus
// per-scenario inline checks.
module tb_audio_play_ctrl;

  logic        clk;
  logic        reset;
  logic        sample_tick;
  logic        play_en;
  logic        playing;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  int model_vol = 64;
  logic [31:0] exp_q[$];

  audio_play_ctrl_if bus();

  audio_play_ctrl #(
    .VOL_SHIFT     (6),
    .VOL_DEFAULT   (64),
    .UCNT_W        (16),
    .FLUSH_ON_STOP (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .play_en      (play_en),
    .bus          (bus),
    .playing      (playing),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_scale(input logic [15:0] s, input int vol);
    int p;
    p = int'($signed(s)) * vol;
    p = p >>> 6;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] d, input int vol);
    return {model_scale(d[31:16], vol), model_scale(d[15:0], vol)};
  endfunction

  // Scoreboard: every dac_valid must match the oldest expected pair.
  always @(negedge clk) begin
    if (bus.dac_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dac_unexpected: got %h_%h with nothing expected", bus.dac_left,
                 bus.dac_right);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({bus.dac_left, bus.dac_right} !== e) begin
          errors++;
          $display("FAIL dac_sample: got %h_%h, expected %h_%h", bus.dac_left, bus.dac_right,
                   e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic do_tick(input logic v, input logic [31:0] d, input logic push,
                         input logic [31:0] exp);
    sample_tick    = 1'b1;
    bus.fifo_valid = v;
    bus.fifo_data  = d;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    sample_tick    = 1'b0;
    bus.fifo_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d samples pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_tick = 1'b0; play_en = 1'b0;
    bus.fifo_valid = 1'b0; bus.fifo_data = '0; bus.vol_req = 1'b0; bus.vol_level = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.fifo_ready !== 1'b0) begin errors++;
      $display("FAIL rst_fifo_ready: got %b, expected 0", bus.fifo_ready); end
    checks++; if (bus.vol_set !== 1'b0) begin errors++;
      $display("FAIL rst_vol_set: got %b, expected 0", bus.vol_set); end
    checks++; if (bus.vol_ready !== 1'b1) begin errors++;
      $display("FAIL rst_vol_ready: got %b, expected 1", bus.vol_ready); end
    checks++; if ({bus.dac_left, bus.dac_right} !== 32'h0) begin errors++;
      $display("FAIL rst_dac: got %h_%h, expected 0", bus.dac_left, bus.dac_right); end
    checks++; if (bus.dac_valid !== 1'b0) begin errors++;
      $display("FAIL rst_dac_valid: got %b, expected 0", bus.dac_valid); end
    checks++; if (playing !== 1'b0) begin errors++;
      $display("FAIL rst_playing: got %b, expected 0", playing); end
    checks++; if (underrun_cnt !== 16'h0) begin errors++;
      $display("FAIL rst_underrun: got %h, expected 0", underrun_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_play();
    play_en = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b1; bus.fifo_valid = 1'b1; bus.fifo_data = 32'h1000_F000;
    exp_q.push_back(model_word(32'h1000_F000, model_vol));
    @(negedge clk);
    checks++; if (bus.fifo_ready !== 1'b1) begin errors++;
      $display("FAIL play_fifo_ready: got %b, expected 1", bus.fifo_ready); end
    @(posedge clk);
    #1 sample_tick = 1'b0; bus.fifo_valid = 1'b0;
    checks++; if (playing !== 1'b1) begin errors++;
      $display("FAIL play_playing: got %b, expected 1", playing); end
    @(negedge clk);
    checks++; if (bus.dac_valid !== 1'b0) begin errors++;
      $display("FAIL play_early_valid: got %b, expected 0", bus.dac_valid); end
    @(negedge clk);
    checks++; if (bus.dac_valid !== 1'b1 || {bus.dac_left, bus.dac_right} !== 32'h1000_F000)
      begin errors++;
      $display("FAIL play_first: got v=%b %h_%h, expected v=1 1000_f000", bus.dac_valid,
               bus.dac_left, bus.dac_right); end
    drain("play");
  endtask

  task automatic test_volume(input logic [6:0] level, input logic [31:0] data);
    bus.vol_req = 1'b1; bus.vol_level = level;
    @(posedge clk);
    #1;
    checks++; if (bus.vol_ready !== 1'b0 || bus.vol_set !== 1'b0) begin errors++;
      $display("FAIL vol_pend: got ready=%b set=%b, expected 0 0", bus.vol_ready,
               bus.vol_set); end
    @(posedge clk);
    #1;
    checks++; if (bus.vol_set !== 1'b0) begin errors++;
      $display("FAIL vol_wait_tick: got set=%b, expected 0", bus.vol_set); end
    model_vol = int'(level);
    do_tick(1'b1, data, 1'b1, model_word(data, model_vol));
    checks++; if (bus.vol_set !== 1'b1) begin errors++;
      $display("FAIL vol_set: got %b, expected 1", bus.vol_set); end
    bus.vol_req = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.vol_set !== 1'b0 || bus.vol_ready !== 1'b1) begin errors++;
      $display("FAIL vol_release: got set=%b ready=%b, expected 0 1", bus.vol_set,
               bus.vol_ready); end
    drain("volume");
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[4];
    words[0] = 32'h8000_C000;
    words[1] = 32'h7FFF_0040;
    words[2] = $urandom();
    words[3] = $urandom();
    for (int i = 0; i < 4; i++) do_tick(1'b1, words[i], 1'b1, model_word(words[i], model_vol));
    drain("b2b");
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 3; i++) do_tick(1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0);
    drain("underrun");
    checks++; if (underrun_cnt !== 16'd3) begin errors++;
      $display("FAIL underrun_cnt: got %0d, expected 3", underrun_cnt); end
    checks++; if (playing !== 1'b1) begin errors++;
      $display("FAIL underrun_playing: got %b, expected 1", playing); end
  endtask

  task automatic test_flush();
    play_en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (playing !== 1'b0) begin errors++;
      $display("FAIL flush_playing: got %b, expected 0", playing); end
    for (int i = 0; i < 4; i++) begin
      sample_tick = 1'b1; bus.fifo_valid = 1'b1; bus.fifo_data = 32'h1111_2222 * (i + 1);
      exp_q.push_back(32'h0);
      @(negedge clk);
      checks++; if (bus.fifo_ready !== 1'b1) begin errors++;
        $display("FAIL flush_ready_%0d: got %b, expected 1", i, bus.fifo_ready); end
      @(posedge clk);
      #1 sample_tick = 1'b0; bus.fifo_valid = 1'b0;
    end
    drain("flush");
    checks++; if (underrun_cnt !== 16'd3) begin errors++;
      $display("FAIL flush_underrun: got %0d, expected 3", underrun_cnt); end
  endtask

  task automatic test_underrun_sat();
    play_en = 1'b1;
    @(posedge clk);
    #1;
    do_tick(1'b1, 32'h0100_0200, 1'b1, model_word(32'h0100_0200, model_vol));
    for (int i = 0; i < 65530; i++) do_tick(1'b0, 32'h0, 1'b1, 32'h0);
    drain("sat_mid");
    checks++; if (underrun_cnt !== 16'd65533) begin errors++;
      $display("FAIL underrun_near: got %0d, expected 65533", underrun_cnt); end
    for (int i = 0; i < 10; i++) do_tick(1'b0, 32'h0, 1'b1, 32'h0);
    drain("sat_end");
    checks++; if (underrun_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL underrun_sat: got %h, expected ffff", underrun_cnt); end
  endtask

  task automatic test_reset_mid();
    do_tick(1'b1, 32'h4000_4000, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.dac_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_valid: got %b, expected 0", bus.dac_valid); end
    checks++; if (playing !== 1'b0 || bus.vol_ready !== 1'b1 || bus.vol_set !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got play=%b ready=%b set=%b, expected 0 1 0",
                         playing, bus.vol_ready, bus.vol_set); end
    checks++; if ({bus.dac_left, bus.dac_right} !== 32'h0 || underrun_cnt !== 16'h0) begin
      errors++; $display("FAIL rstmid_data: got %h_%h cnt=%h, expected 0 0 0", bus.dac_left,
                         bus.dac_right, underrun_cnt); end
    @(posedge clk);
    #1;
    model_vol = 64;
    do_tick(1'b1, 32'h1234_ABCD, 1'b1, model_word(32'h1234_ABCD, model_vol));
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_play();
    test_volume(7'd127, 32'h7000_0100);
    test_back_to_back();
    test_volume(7'd0, 32'h7FFF_8000);
    test_underrun();
    test_flush();
    test_underrun_sat();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
